// File: rtl/pc_pkg.sv
// Shared constants, selection encoding and helpers for the program counter unit.
package pc_pkg;

    localparam int unsigned CAUSE_W       = 5;
    localparam int unsigned DEF_WIDTH     = 32;
    localparam int unsigned DEF_STEP      = 4;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0008;

    // Cause codes written on trap entry.
    localparam logic [CAUSE_W-1:0] IRQ_CODE   = 5'd0;
    localparam logic [CAUSE_W-1:0] ALIGN_CODE = 5'd4;

    // Source of the next fetch address, lowest to highest priority.
    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_ERET,
        SEL_IRQ,
        SEL_ALIGN,
        SEL_EXC
    } sel_e;

    // A branch target is misaligned when it is not on a word boundary.
    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-state selection for the program counter unit.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned       WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0]  EXC_VEC = WIDTH'(DEF_EXC_VEC),
    parameter int unsigned       STEP    = DEF_STEP
) (
    input  logic [WIDTH-1:0]   pc,
    input  logic [WIDTH-1:0]   epc,
    input  logic [CAUSE_W-1:0] cause,
    input  logic               ie,
    input  logic               irq_pend,
    input  logic               br_take,
    input  logic [WIDTH-1:0]   br_target,
    input  logic               exc,
    input  logic [CAUSE_W-1:0] exc_code,
    input  logic               eret,
    output logic [WIDTH-1:0]   pc_next_c,
    output logic [WIDTH-1:0]   epc_next_c,
    output logic [CAUSE_W-1:0] cause_next_c,
    output logic               ie_next_c,
    output logic               trap_c,
    output logic               irq_take_c
);

    sel_e             sel;
    logic [WIDTH-1:0] seq_addr;
    logic [WIDTH-1:0] resume_addr;
    logic             br_fault;

    // Sequential address wraps naturally at the top of the address space.
    assign seq_addr    = pc + WIDTH'(STEP);
    assign br_fault    = br_take & misaligned(br_target[1:0]);
    // Where execution would have continued had the interrupt not been taken.
    assign resume_addr = br_take ? br_target : seq_addr;

    // Priority encode the redirect source.
    always_comb begin
        sel = SEL_SEQ;
        if (exc) begin
            sel = SEL_EXC;
        end else if (br_fault) begin
            sel = SEL_ALIGN;
        end else if (irq_pend && ie) begin
            sel = SEL_IRQ;
        end else if (eret) begin
            sel = SEL_ERET;
        end else if (br_take) begin
            sel = SEL_BRANCH;
        end
    end

    // Produce next architectural state for the selected source.
    always_comb begin
        pc_next_c    = seq_addr;
        epc_next_c   = epc;
        cause_next_c = cause;
        ie_next_c    = ie;
        trap_c       = 1'b0;
        irq_take_c   = 1'b0;
        case (sel)
            SEL_EXC: begin
                pc_next_c    = EXC_VEC;
                epc_next_c   = pc;
                cause_next_c = exc_code;
                ie_next_c    = 1'b0;
                trap_c       = 1'b1;
            end
            SEL_ALIGN: begin
                pc_next_c    = EXC_VEC;
                epc_next_c   = pc;
                cause_next_c = ALIGN_CODE;
                ie_next_c    = 1'b0;
                trap_c       = 1'b1;
            end
            SEL_IRQ: begin
                pc_next_c    = EXC_VEC;
                epc_next_c   = resume_addr;
                cause_next_c = IRQ_CODE;
                ie_next_c    = 1'b0;
                trap_c       = 1'b1;
                irq_take_c   = 1'b1;
            end
            SEL_ERET: begin
                pc_next_c = epc;
                ie_next_c = 1'b1;
            end
            SEL_BRANCH: begin
                pc_next_c = br_target;
            end
            default: begin
                pc_next_c = seq_addr;
            end
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with exception, interrupt and return-from-handler support.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned       WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VEC = WIDTH'(DEF_RESET_VEC),
    parameter logic [WIDTH-1:0]  EXC_VEC   = WIDTH'(DEF_EXC_VEC),
    parameter int unsigned       STEP      = DEF_STEP
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               En,
    input  logic               Br_take,
    input  logic [WIDTH-1:0]   Br_target,
    input  logic               Exc,
    input  logic [CAUSE_W-1:0] Exc_code,
    input  logic               Irq,
    input  logic               Eret,
    output logic [WIDTH-1:0]   Pc,
    output logic [WIDTH-1:0]   Epc,
    output logic [CAUSE_W-1:0] Cause,
    output logic               Ie,
    output logic               Trap
);

    logic               irq_pend;
    logic [WIDTH-1:0]   pc_next_c;
    logic [WIDTH-1:0]   epc_next_c;
    logic [CAUSE_W-1:0] cause_next_c;
    logic               ie_next_c;
    logic               trap_c;
    logic               irq_take_c;

    pc_next_sel #(
        .WIDTH   (WIDTH),
        .EXC_VEC (EXC_VEC),
        .STEP    (STEP)
    ) u_next_sel (
        .pc           (Pc),
        .epc          (Epc),
        .cause        (Cause),
        .ie           (Ie),
        .irq_pend     (irq_pend),
        .br_take      (Br_take),
        .br_target    (Br_target),
        .exc          (Exc),
        .exc_code     (Exc_code),
        .eret         (Eret),
        .pc_next_c    (pc_next_c),
        .epc_next_c   (epc_next_c),
        .cause_next_c (cause_next_c),
        .ie_next_c    (ie_next_c),
        .trap_c       (trap_c),
        .irq_take_c   (irq_take_c)
    );

    // Architectural state; a stall freezes everything except interrupt capture.
    // A new Irq arriving in the cycle the previous one is taken re-arms pending.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Pc       <= RESET_VEC;
            Epc      <= '0;
            Cause    <= '0;
            Ie       <= 1'b1;
            irq_pend <= 1'b0;
            Trap     <= 1'b0;
        end else begin
            irq_pend <= (irq_pend & ~(En & irq_take_c)) | Irq;
            Trap     <= En & trap_c;
            if (En) begin
                Pc    <= pc_next_c;
                Epc   <= epc_next_c;
                Cause <= cause_next_c;
                Ie    <= ie_next_c;
            end
        end
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC/EPC width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, PC value after reset.
REQ-003 SHALL have parameter EXC_VEC, default 32'h0000_0008, handler entry address for all exceptions and interrupts.
REQ-004 SHALL have parameter STEP, default 4, sequential increment.
REQ-005 SHALL have port Clk, input, 1, the single clock; all state updates on posedge Clk.
REQ-006 SHALL have port Rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port En, input, 1, advance enable; 0 = stall, all state holds except irq_pend capture.
REQ-008 SHALL have port Br_take, input, 1, redirect to Br_target.
REQ-009 SHALL have port Br_target, input, WIDTH, branch/jump destination.
REQ-010 SHALL have port Exc, input, 1, synchronous exception from current instruction.
REQ-011 SHALL have port Exc_code, input, 5, cause code accompanying Exc.
REQ-012 SHALL have port Irq, input, 1, external interrupt request (pulse or level).
REQ-013 SHALL have port Eret, input, 1, return from handler.
REQ-014 SHALL have port Pc, output, WIDTH, current fetch address (registered).
REQ-015 SHALL have port Epc, output, WIDTH, saved return address (registered).
REQ-016 SHALL have port Cause, output, 5, last trap cause (registered).
REQ-017 SHALL have port Ie, output, 1, interrupt enable status.
REQ-018 SHALL have port Trap, output, 1, registered one-cycle pulse, high the cycle after any exception/interrupt redirect.

Function
REQ-019 SHALL set irq_pend on any cycle Irq=1 regardless of En; cleared only when the interrupt is taken or on Rst.
REQ-020 SHALL, when En=1, select next Pc by priority: Exc > alignment fault > interrupt (irq_pend & Ie) > Eret > Br_take > Pc+STEP.
REQ-021 SHALL raise alignment fault when Br_take=1 and Br_target[1:0]!=0; Cause<=ALIGN_CODE, Epc<=Pc, Pc<=EXC_VEC, Ie<=0.
REQ-022 SHALL on Exc: Epc<=Pc, Cause<=Exc_code, Ie<=0, Pc<=EXC_VEC.
REQ-023 SHALL on interrupt: Epc<=address that would otherwise load (Br_target if Br_take valid, else Pc+STEP), Cause<=IRQ_CODE, Ie<=0, irq_pend<=0, Pc<=EXC_VEC.
REQ-024 SHALL on Eret: Pc<=Epc, Ie<=1; Epc and Cause unchanged.
REQ-025 SHALL compute Pc+STEP modulo 2^WIDTH (wrap all-ones region to low addresses, no fault).
REQ-026 SHALL, when En=0, hold Pc, Epc, Cause, Ie and ignore Exc, Eret, Br_take (upstream re-presents them).
REQ-027 SHALL take a pending interrupt raised while Ie=0 on the first En=1 cycle after Ie returns to 1, not in the same cycle as the Eret.
REQ-028 SHALL assert Trap exactly one cycle after REQ-021/022/023 redirects; 0 otherwise.

Reset
REQ-029 SHALL on Rst=1 at posedge Clk: Pc<=RESET_VEC, Epc<=0, Cause<=0, Ie<=1, irq_pend<=0, Trap<=0; Rst overrides En, Exc, Irq, Eret in the same cycle.
REQ-030 SHALL discard an in-flight redirect or pending interrupt when Rst asserts mid-operation.

Structure
REQ-031 SHALL place IRQ_CODE (5'd0), ALIGN_CODE (5'd4) and default vector constants in shared package pc_pkg.
REQ-032 SHALL isolate the combinational priority selection in one sub-module pc_next_sel; registers stay in pc_unit.

Verification
REQ-033 SHALL test reset then 3 En cycles: Pc 0 -> 4 -> 8 -> C; Ie=1, Trap=0.
REQ-034 SHALL test Pc=0x10, Exc=1, Exc_code=12: next Pc=0x08, Epc=0x10, Cause=12, Ie=0, Trap=1 one cycle later.
REQ-035 SHALL test Irq pulse while En=0 at Pc=0x20, then En=1: Pc=0x08, Epc=0x24, Cause=0; Irq again with Ie=0 held until Eret, taken the cycle after.
REQ-036 SHALL test Br_take with Br_target=0x102: alignment trap, Epc=Pc, Cause=4; Br_target=0x100 loads 0x100.
REQ-037 SHALL test simultaneous Exc+Irq+Eret+Br_take: Exc wins, irq_pend stays set; Pc=0xFFFF_FFFC with En wraps to 0x0; Rst during Exc yields Pc=RESET_VEC, Trap=0.
